// File: rtl/flag_pkg.sv
// Shared flag-register definitions: flag widths, bit positions, the always-true condition code,
// query FSM states and the masked-merge helper.
package flag_pkg;

  localparam int FLAG_W = 7;

  localparam int FLG_COL  = 0;
  localparam int FLG_ZIW1 = 1;
  localparam int FLG_ZIW2 = 2;
  localparam int FLG_ZIMM = 3;
  localparam int FLG_CO   = 4;
  localparam int FLG_CALL = 5;
  localparam int FLG_SIGN = 6;

  localparam logic [2:0] COND_ALWAYS = 3'd7;

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_WAIT,
    Q_RESOLVE
  } cond_state_e;

  function automatic logic [FLAG_W-1:0] flag_merge(input logic [FLAG_W-1:0] cur,
                                                   input logic [FLAG_W-1:0] val,
                                                   input logic [FLAG_W-1:0] mask);
    return (cur & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/flag_write_ctrl_if.sv
// Bundle of flag-write, issue-tracking and branch-query signals around the flag controller.
// master drives requests and queries; slave is the controller itself.
interface flag_write_ctrl_if;
  import flag_pkg::*;

  logic              flush;
  logic              alu_req;
  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] alu_mask;
  logic              alu_gnt;
  logic              pim_req;
  logic [FLAG_W-1:0] pim_flags;
  logic [FLAG_W-1:0] pim_mask;
  logic              pim_gnt;
  logic              issue_set;
  logic              pend_full;
  logic              pend_err;
  logic              cond_req;
  logic [2:0]        cond_sel;
  logic              cond_inv;
  logic              cond_stall;
  logic              cond_valid;
  logic              cond_taken;
  logic [FLAG_W-1:0] flag;

  modport master (
    output flush, alu_req, alu_flags, alu_mask, pim_req, pim_flags, pim_mask,
           issue_set, cond_req, cond_sel, cond_inv,
    input  alu_gnt, pim_gnt, pend_full, pend_err, cond_stall, cond_valid, cond_taken, flag
  );

  modport slave (
    input  flush, alu_req, alu_flags, alu_mask, pim_req, pim_flags, pim_mask,
           issue_set, cond_req, cond_sel, cond_inv,
    output alu_gnt, pim_gnt, pend_full, pend_err, cond_stall, cond_valid, cond_taken, flag
  );

endinterface

// File: rtl/flag_rr_arb2.sv
// Two-requester round-robin arbiter; grants are combinational, same cycle as request.
// Preference flips only when both sides request together.
module flag_rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  // 0: side A wins the next contention, 1: side B wins it
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt_a_o  = req_a_i & (~req_b_i | ~rr_ptr_q);
    gnt_b_o  = req_b_i & (~req_a_i |  rr_ptr_q);
    rr_ptr_d = rr_ptr_q;
    if (req_a_i && req_b_i) rr_ptr_d = gnt_a_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= 1'b0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/flag_write_ctrl.sv
// Flag register owner: arbitrates ALU/PIM masked writes (grant same cycle, flag updates next edge),
// counts in-flight flag writers and answers branch queries once pending writes have landed.
module flag_write_ctrl
  import flag_pkg::*;
#(
  parameter int PEND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  flag_write_ctrl_if.slave  bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic              alu_gnt, pim_gnt, any_gnt, pend_full;
  logic [FLAG_W-1:0] flag_q, flag_d, wr_val, wr_mask;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              pend_err_q, pend_err_d;
  cond_state_e       state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic              inv_q, inv_d;
  logic [FLAG_W:0]   cond_vec;

  flag_rr_arb2 u_arb (
    .clk_i   (clk),
    .rst_i   (rst),
    .req_a_i (bus.alu_req),
    .req_b_i (bus.pim_req),
    .gnt_a_o (alu_gnt),
    .gnt_b_o (pim_gnt)
  );

  assign any_gnt   = alu_gnt | pim_gnt;
  assign pend_full = (pend_q == PEND_MAX);
  assign wr_val    = pim_gnt ? bus.pim_flags : bus.alu_flags;
  assign wr_mask   = pim_gnt ? bus.pim_mask  : bus.alu_mask;

  always_comb begin
    flag_d = flag_q;
    if (any_gnt) flag_d = flag_merge(flag_q, wr_val, wr_mask);
    if (bus.flush) flag_d = '0;
  end

  // An issue and a grant in the same cycle cancel out; saturate at both ends
  always_comb begin
    pend_d     = pend_q;
    pend_err_d = pend_err_q | (bus.issue_set & pend_full & ~any_gnt);
    if (bus.issue_set && !any_gnt && !pend_full)
      pend_d = pend_q + PEND_ONE;
    else if (!bus.issue_set && any_gnt && pend_q != '0)
      pend_d = pend_q - PEND_ONE;
    if (bus.flush) pend_d = '0;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    inv_d   = inv_q;
    case (state_q)
      Q_IDLE: begin
        if (bus.cond_req) begin
          sel_d   = bus.cond_sel;
          inv_d   = bus.cond_inv;
          state_d = (pend_q == '0 && !any_gnt) ? Q_RESOLVE : Q_WAIT;
        end
      end
      Q_WAIT:    if (pend_q == '0 && !any_gnt) state_d = Q_RESOLVE;
      Q_RESOLVE: state_d = Q_IDLE;
      default:   state_d = Q_IDLE;
    endcase
    if (bus.flush) state_d = Q_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q     <= '0;
      pend_q     <= '0;
      pend_err_q <= 1'b0;
      state_q    <= Q_IDLE;
      sel_q      <= '0;
      inv_q      <= 1'b0;
    end else begin
      flag_q     <= flag_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      inv_q      <= inv_d;
    end
  end

  // Top bit makes COND_ALWAYS index a constant 1
  assign cond_vec = {1'b1, flag_q};

  assign bus.alu_gnt    = alu_gnt;
  assign bus.pim_gnt    = pim_gnt;
  assign bus.pend_full  = pend_full;
  assign bus.pend_err   = pend_err_q;
  assign bus.cond_stall = (state_q == Q_WAIT);
  assign bus.cond_valid = (state_q == Q_RESOLVE);
  assign bus.cond_taken = (state_q == Q_RESOLVE) & (cond_vec[sel_q] ^ inv_q);
  assign bus.flag       = flag_q;

endmodule
